vc_allocator: RTL and testbench

- Router-level virtual-channel allocator: assigns a free downstream VC on the requested output port to each input VC in its VA state.
- Drives the `vc_valid`/`vc_new` pair that moves input buffers from VA to SA.
- Keeps a per-output-port availability map of downstream VCs, updated by tail-flit releases from the switch side.
- Sits between the input ports and the switch allocator; one instance per router.

---
 rtl/noc_params.sv | 24 ++
 rtl/round_robin_arbiter.sv | 36 +++
 rtl/vc_allocator.sv | 116 +++++++++++
 tb/tb_vc_allocator.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Router-wide parameters and the output-port encoding shared by the
// allocator and its arbiters.
//   PORT_NUM : router ports (inputs == outputs)
//   VC_NUM   : virtual channels per port
//   VC_SIZE  : width of a VC id
//   VC_TOTAL : number of input VCs across the router
//   PTR_W    : width of a round-robin pointer over all input VCs
package noc_params;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_SIZE  = $clog2(VC_NUM);
    localparam int VC_TOTAL = PORT_NUM * VC_NUM;
    localparam int PTR_W    = $clog2(VC_TOTAL);

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above ptr, scanning upward and wrapping from N-1 to 0.
//   req       : request vector
//   ptr       : highest-priority index for this cycle
//   grant     : one-hot winner (all zero when no request)
//   grant_idx : binary index of the winner (0 when no request)
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    always_comb begin
        int  idx;
        logic found;
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ($clog2(N))'(idx);
            end
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// Router virtual-channel allocator. Each input VC in its VA state asks for a
// downstream VC on one output port; every output port independently grants
// one requester per cycle (round-robin) the lowest-numbered free VC.
//   clk          : clock
//   rst          : asynchronous active-low reset
//   va_req_i     : input VC i is in VA (i = port*VC_NUM + vc)
//   out_port_i   : requested output port of each input VC
//   vc_release_i : per output port, downstream VCs freed by a tail flit
//   vc_valid_o   : one-cycle grant strobe per input VC
//   vc_new_o     : granted downstream VC id, held between grants
module vc_allocator
    import noc_params::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [VC_TOTAL-1:0] va_req_i,
    input  port_t               out_port_i   [VC_TOTAL],
    input  logic [VC_NUM-1:0]   vc_release_i [PORT_NUM],
    output logic [VC_TOTAL-1:0] vc_valid_o,
    output logic [VC_SIZE-1:0]  vc_new_o     [VC_TOTAL]
);

    logic [VC_NUM-1:0]   avail   [PORT_NUM];
    logic [PTR_W-1:0]    rr_ptr  [PORT_NUM];

    logic [VC_TOTAL-1:0] req_eff;
    logic [VC_TOTAL-1:0] cand    [PORT_NUM];
    logic [VC_TOTAL-1:0] win     [PORT_NUM];
    logic [PTR_W-1:0]    win_idx [PORT_NUM];
    logic [VC_SIZE-1:0]  free_vc [PORT_NUM];
    logic [VC_NUM-1:0]   free_oh [PORT_NUM];
    logic [PORT_NUM-1:0] do_grant;
    logic [VC_TOTAL-1:0] valid_nxt;
    logic [VC_SIZE-1:0]  new_nxt [VC_TOTAL];

    // A requester stays in VA for the cycle its grant strobe is visible;
    // masking it here prevents a second grant to the same buffer.
    assign req_eff = va_req_i & ~vc_valid_o;

    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int i = 0; i < VC_TOTAL; i++) begin
                cand[p][i] = req_eff[i] && (out_port_i[i] == port_t'(p));
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_arb
        round_robin_arbiter #(.N(VC_TOTAL)) u_arb (
            .req       (cand[p]),
            .ptr       (rr_ptr[p]),
            .grant     (win[p]),
            .grant_idx (win_idx[p])
        );
    end

    // Lowest-index free downstream VC per output port; the descending scan
    // lets the lowest set bit overwrite any higher one.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            free_vc[p] = '0;
            free_oh[p] = '0;
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                if (avail[p][v]) begin
                    free_vc[p] = VC_SIZE'(v);
                    free_oh[p] = VC_NUM'(1) << v;
                end
            end
            do_grant[p] = (|cand[p]) && (|avail[p]);
        end
    end

    // Each input VC targets exactly one output port, so at most one port's
    // winner vector can touch a given output slot.
    always_comb begin
        valid_nxt = '0;
        new_nxt   = vc_new_o;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int i = 0; i < VC_TOTAL; i++) begin
                if (do_grant[p] && win[p][i]) begin
                    valid_nxt[i] = 1'b1;
                    new_nxt[i]   = free_vc[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these arrays are small control state, not RAM, so every
            // entry is reset explicitly; a stale vc id or availability bit
            // after reset would corrupt allocation.
            vc_valid_o <= '0;
            for (int i = 0; i < VC_TOTAL; i++) vc_new_o[i] <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                avail[p]  <= '1;
                rr_ptr[p] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update based
            // on pre-edge values, so allocation sees the old avail map even
            // when a release lands on the same edge.
            vc_valid_o <= valid_nxt;
            vc_new_o   <= new_nxt;
            for (int p = 0; p < PORT_NUM; p++) begin
                avail[p] <= (avail[p] & ~(do_grant[p] ? free_oh[p] : '0))
                            | vc_release_i[p];
                if (do_grant[p]) begin
                    rr_ptr[p] <= (win_idx[p] == PTR_W'(VC_TOTAL - 1))
                                 ? '0 : win_idx[p] + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_allocator.sv
module tb_vc_allocator;
    import noc_params::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [VC_TOTAL-1:0] va_req;
    port_t               out_port   [VC_TOTAL];
    logic [VC_NUM-1:0]   vc_release [PORT_NUM];
    logic [VC_TOTAL-1:0] vc_valid;
    logic [VC_SIZE-1:0]  vc_new     [VC_TOTAL];

    int checks = 0;
    int errors = 0;

    vc_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .va_req_i     (va_req),
        .out_port_i   (out_port),
        .vc_release_i (vc_release),
        .vc_valid_o   (vc_valid),
        .vc_new_o     (vc_new)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        va_req = '0;
        for (int i = 0; i < VC_TOTAL; i++) out_port[i] = LOCAL;
        for (int p = 0; p < PORT_NUM; p++) vc_release[p] = '0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #12;
        checks++;
        if (vc_valid !== '0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", vc_valid);
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            checks++;
            if (dut.avail[p] !== 2'b11 || dut.rr_ptr[p] !== '0) begin
                errors++;
                $display("FAIL reset_state p%0d: avail %b ptr %0d want 11/0", p, dut.avail[p], dut.rr_ptr[p]);
            end
        end
        for (int i = 0; i < VC_TOTAL; i++) begin
            checks++;
            if (vc_new[i] !== '0) begin
                errors++; $display("FAIL reset_new %0d: got %0d want 0", i, vc_new[i]);
            end
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_grant();
        do_reset();
        va_req[0] = 1'b1; out_port[0] = EAST;
        step();
        checks++;
        if (vc_valid !== 10'b0000000001 || vc_new[0] !== 1'b0) begin
            errors++; $display("FAIL single_grant: valid %b new %0d want 0000000001/0", vc_valid, vc_new[0]);
        end
        checks++;
        if (dut.avail[EAST] !== 2'b10 || dut.rr_ptr[EAST] !== 4'd1) begin
            errors++; $display("FAIL single_avail: avail %b ptr %0d want 10/1", dut.avail[EAST], dut.rr_ptr[EAST]);
        end
        step();  // request still high during the grant cycle: must be masked
        checks++;
        if (vc_valid !== '0) begin
            errors++; $display("FAIL single_one_cycle: valid %b want 0", vc_valid);
        end
        clear_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        va_req[2] = 1'b1; va_req[4] = 1'b1; va_req[6] = 1'b1;
        out_port[2] = NORTH; out_port[4] = NORTH; out_port[6] = NORTH;
        step();  // cycle 1
        checks++;
        if (vc_valid !== 10'b0000000100 || vc_new[2] !== 1'b0) begin
            errors++; $display("FAIL contention_c1: valid %b new %0d want 0000000100/0", vc_valid, vc_new[2]);
        end
        step();  // cycle 2
        checks++;
        if (vc_valid !== 10'b0000010000 || vc_new[4] !== 1'b1) begin
            errors++; $display("FAIL contention_c2: valid %b new %0d want 0000010000/1", vc_valid, vc_new[4]);
        end
        va_req[2] = 1'b0;
        step();  // cycle 3
        va_req[4] = 1'b0;
        step();  // cycle 4
        step();  // cycle 5
        checks++;
        if (vc_valid !== '0) begin
            errors++; $display("FAIL contention_wait: valid %b want 0", vc_valid);
        end
        vc_release[NORTH] = 2'b01;
        step();  // cycle 6
        vc_release[NORTH] = 2'b00;
        checks++;
        if (vc_valid !== '0) begin
            errors++; $display("FAIL contention_c6: valid %b want 0", vc_valid);
        end
        step();  // cycle 7
        checks++;
        if (vc_valid !== 10'b0001000000 || vc_new[6] !== 1'b0) begin
            errors++; $display("FAIL contention_c7: valid %b new %0d want 0001000000/0", vc_valid, vc_new[6]);
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        int due [VC_NUM];
        int order [$];
        int cur;
        int idx;
        do_reset();
        for (int v = 0; v < VC_NUM; v++) due[v] = -1;
        va_req[1] = 1'b1; va_req[3] = 1'b1;
        out_port[1] = WEST; out_port[3] = WEST;
        cur = 0;
        for (int n = 0; n < 30 && order.size() < 4; n++) begin
            for (int v = 0; v < VC_NUM; v++) vc_release[WEST][v] = (due[v] == cur);
            step();
            cur++;
            idx = -1;
            if (vc_valid[1]) idx = 1;
            if (vc_valid[3]) idx = 3;
            if (idx >= 0) begin
                order.push_back(idx);
                due[int'(vc_new[idx])] = cur + 2;
                if (order.size() == 1) begin
                    checks++;
                    if (dut.rr_ptr[WEST] !== 4'd2) begin
                        errors++; $display("FAIL fairness_ptr: got %0d want 2", dut.rr_ptr[WEST]);
                    end
                end
            end
        end
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL fairness_count: got %0d grants want 4", order.size());
        end else if (order[0] != 1 || order[1] != 3 || order[2] != 1 || order[3] != 3) begin
            errors++; $display("FAIL fairness_order: got %0d %0d %0d %0d want 1 3 1 3", order[0], order[1], order[2], order[3]);
        end
        clear_inputs();
    endtask

    task automatic test_parallel();
        logic bad;
        do_reset();
        for (int k = 0; k < PORT_NUM; k++) begin
            va_req[2*k] = 1'b1;
            out_port[2*k] = port_t'(k);
        end
        step();
        checks++;
        if (vc_valid !== 10'b0101010101) begin
            errors++; $display("FAIL parallel_valid: got %b want 0101010101", vc_valid);
        end
        bad = 1'b0;
        for (int k = 0; k < PORT_NUM; k++) if (vc_new[2*k] !== 1'b0) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL parallel_new: some granted vc_new not 0");
        end
        clear_inputs();
    endtask

    task automatic test_same_cycle_release();
        do_reset();
        va_req[7] = 1'b1; va_req[9] = 1'b1;
        out_port[7] = NORTH; out_port[9] = NORTH;
        step();
        va_req[7] = 1'b0;
        step();
        checks++;
        if (vc_valid !== 10'b1000000000 || dut.avail[NORTH] !== 2'b00) begin
            errors++; $display("FAIL samecyc_fill: valid %b avail %b want 1000000000/00", vc_valid, dut.avail[NORTH]);
        end
        va_req = '0;
        va_req[5] = 1'b1; out_port[5] = NORTH;
        vc_release[NORTH] = 2'b10;
        step();  // k+1
        vc_release[NORTH] = 2'b00;
        checks++;
        if (vc_valid !== '0) begin
            errors++; $display("FAIL samecyc_k1: valid %b want 0", vc_valid);
        end
        step();  // k+2
        checks++;
        if (vc_valid !== 10'b0000100000 || vc_new[5] !== 1'b1) begin
            errors++; $display("FAIL samecyc_k2: valid %b new %0d want 0000100000/1", vc_valid, vc_new[5]);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        for (int i = 0; i < VC_TOTAL; i++) begin
            va_req[i] = 1'b1;
            out_port[i] = port_t'(i / 2);
        end
        step();
        step();
        bad = 1'b0;
        for (int p = 0; p < PORT_NUM; p++) if (dut.avail[p] !== 2'b00) bad = 1'b1;
        checks++;
        if (vc_valid[3] !== 1'b1 || bad) begin
            errors++; $display("FAIL midrst_pre: valid %b avail_nonzero %b want valid[3]=1 avail 0", vc_valid, bad);
        end
        va_req = '0;
        #2 rst = 1'b0;
        #1;
        bad = 1'b0;
        for (int p = 0; p < PORT_NUM; p++)
            if (dut.avail[p] !== 2'b11 || dut.rr_ptr[p] !== '0) bad = 1'b1;
        checks++;
        if (vc_valid !== '0 || bad) begin
            errors++; $display("FAIL midrst_clear: valid %b state_bad %b want 0/0", vc_valid, bad);
        end
        #1 rst = 1'b1;
        va_req[4] = 1'b1; out_port[4] = SOUTH;
        step();
        checks++;
        if (vc_valid !== 10'b0000010000 || vc_new[4] !== 1'b0) begin
            errors++; $display("FAIL midrst_regrant: valid %b new %0d want 0000010000/0", vc_valid, vc_new[4]);
        end
        clear_inputs();
    endtask

    // Random traffic against a model built from the allocation rules:
    // per output, scan requesters round-robin from the pointer and hand out
    // the lowest free VC from a bitmap of free downstream VCs.
    task automatic test_random();
        logic [VC_NUM-1:0]   m_avail [PORT_NUM];
        logic [VC_NUM-1:0]   n_avail [PORT_NUM];
        int                  m_ptr   [PORT_NUM];
        int                  n_ptr   [PORT_NUM];
        logic [VC_TOTAL-1:0] m_valid, n_valid;
        int                  m_new   [VC_TOTAL];
        int                  n_new   [VC_TOTAL];
        int                  winner, free, i;
        logic                bad;
        do_reset();
        for (int p = 0; p < PORT_NUM; p++) begin m_avail[p] = '1; m_ptr[p] = 0; end
        m_valid = '0;
        for (int k = 0; k < VC_TOTAL; k++) m_new[k] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < VC_TOTAL; k++) begin
                va_req[k]   = ($urandom_range(0, 99) < 40);
                out_port[k] = port_t'($urandom_range(0, PORT_NUM - 1));
            end
            for (int p = 0; p < PORT_NUM; p++)
                for (int v = 0; v < VC_NUM; v++)
                    vc_release[p][v] = !m_avail[p][v] && ($urandom_range(0, 3) == 0);
            n_valid = '0;
            n_new   = m_new;
            n_avail = m_avail;
            n_ptr   = m_ptr;
            for (int p = 0; p < PORT_NUM; p++) begin
                winner = -1;
                for (int k = 0; k < VC_TOTAL; k++) begin
                    i = (m_ptr[p] + k) % VC_TOTAL;
                    if (winner < 0 && va_req[i] && !m_valid[i] && int'(out_port[i]) == p) winner = i;
                end
                free = -1;
                for (int v = 0; v < VC_NUM; v++) if (free < 0 && m_avail[p][v]) free = v;
                if (winner >= 0 && free >= 0) begin
                    n_valid[winner] = 1'b1;
                    n_new[winner]   = free;
                    n_avail[p][free] = 1'b0;
                    n_ptr[p] = (winner + 1) % VC_TOTAL;
                end
                for (int v = 0; v < VC_NUM; v++) begin
                    if (vc_release[p][v]) begin
                        if (m_avail[p][v]) begin
                            errors++; $display("FAIL protocol: release of free vc p%0d v%0d", p, v);
                        end
                        n_avail[p][v] = 1'b1;
                    end
                end
            end
            step();
            checks++;
            if (vc_valid !== n_valid) begin
                errors++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, vc_valid, n_valid);
            end
            bad = 1'b0;
            for (int k = 0; k < VC_TOTAL; k++) if (int'(vc_new[k]) != n_new[k]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL rand_new cyc %0d: vc_new differs from model", cyc);
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                checks++;
                if (dut.avail[p] !== n_avail[p] || int'(dut.rr_ptr[p]) != n_ptr[p]) begin
                    errors++;
                    $display("FAIL rand_state cyc %0d p%0d: avail %b ptr %0d want %b/%0d", cyc, p, dut.avail[p], dut.rr_ptr[p], n_avail[p], n_ptr[p]);
                end
            end
            m_valid = n_valid;
            m_new   = n_new;
            m_avail = n_avail;
            m_ptr   = n_ptr;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_contention();
        test_fairness();
        test_parallel();
        test_same_cycle_release();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
